// File: rtl/seq_mult_stream_if.sv
// Operand-side and result-side handshake bundle for seq_mult_stream.
// The slave modport is the multiplier; the master modport is its environment.
interface seq_mult_stream_if #(
  parameter int P         = 2,
  parameter int MAX_WIDTH = 16
);
  localparam int NDIG_W = $clog2(MAX_WIDTH / P + 1);

  logic                 in_valid_i;
  logic                 in_ready_o;
  logic [MAX_WIDTH-1:0] a_i;
  logic [MAX_WIDTH-1:0] b_i;
  logic [MAX_WIDTH-1:0] c_i;
  logic                 signed_i;
  logic [NDIG_W-1:0]    ndig_i;
  logic                 out_valid_o;
  logic                 out_ready_i;
  logic [P-1:0]         out_digit_o;
  logic                 out_last_o;

  modport slave (
    input  in_valid_i, a_i, b_i, c_i, signed_i, ndig_i, out_ready_i,
    output in_ready_o, out_valid_o, out_digit_o, out_last_o
  );

  modport master (
    output in_valid_i, a_i, b_i, c_i, signed_i, ndig_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_digit_o, out_last_o
  );
endinterface

// File: rtl/seq_mult_stream.sv
// Digit-serial multiply-add a*b+c, signed or unsigned, runtime width W=ndig*P.
// The 2W-bit result streams out P bits per handshake, LSB digit first.
module seq_mult_stream #(
  parameter int P         = 2,
  parameter int MAX_WIDTH = 16
) (
  input logic              clk_i,
  input logic              rst_n,
  seq_mult_stream_if.slave bus
);
  localparam int NMAX   = MAX_WIDTH / P;
  localparam int NDIG_W = $clog2(NMAX + 1);
  localparam int CNT_W  = $clog2(2 * NMAX + 1);
  localparam int ACC_W  = MAX_WIDTH + P + 1;

  typedef enum logic [1:0] {IDLE, MUL, DRAIN} state_t;

  state_t                     state, state_nxt;
  logic signed [MAX_WIDTH:0]  a_r;
  logic [MAX_WIDTH-1:0]       b_r;
  logic                       sgn_r;
  logic [NDIG_W-1:0]          n_r;
  logic [CNT_W-1:0]           cnt_r;
  logic signed [ACC_W-1:0]    acc_r;

  logic                       hs_in, hs_out, last_mul, last_out;
  logic [NDIG_W-1:0]          n_clamp;
  logic signed [MAX_WIDTH:0]  a_ext, c_ext;
  logic signed [P:0]          b_dig;
  logic signed [ACC_W-1:0]    prod, sum, shifted;

  // Clamp the requested digit count: 0 or out-of-range selects full width.
  function automatic logic [NDIG_W-1:0] clamp_ndig(input logic [NDIG_W-1:0] n);
    if (n == '0 || int'(n) > NMAX) clamp_ndig = NDIG_W'(NMAX);
    else                           clamp_ndig = n;
  endfunction

  // Keep the low n*P bits of an operand and extend to MAX_WIDTH+1 bits per mode.
  function automatic logic signed [MAX_WIDTH:0] ext_op(input logic [MAX_WIDTH-1:0] v,
                                                       input logic [NDIG_W-1:0]    n,
                                                       input logic                 sg);
    int                   shamt;
    logic [MAX_WIDTH-1:0] sh;
    shamt = MAX_WIDTH - int'(n) * P;
    sh    = v << shamt;
    if (sg) ext_op = $signed({sh[MAX_WIDTH-1], sh}) >>> shamt;
    else    ext_op = $signed({1'b0, sh >> shamt});
  endfunction

  // Multiplier digit: unsigned, except the top digit of a signed b weighs its MSB negatively.
  function automatic logic signed [P:0] mult_digit(input logic [P-1:0] d, input logic neg_msb);
    mult_digit = $signed({neg_msb & d[P-1], d});
  endfunction

  // Datapath: partial product, accumulate and shift for the current digit.
  always_comb begin
    n_clamp  = clamp_ndig(bus.ndig_i);
    a_ext    = ext_op(bus.a_i, n_clamp, bus.signed_i);
    c_ext    = ext_op(bus.c_i, n_clamp, bus.signed_i);
    last_mul = (cnt_r == CNT_W'(n_r - 1'b1));
    last_out = (cnt_r == CNT_W'({n_r, 1'b0} - 1'b1));
    b_dig    = mult_digit(b_r[P-1:0], sgn_r & last_mul);
    prod     = ACC_W'(a_r) * ACC_W'(b_dig);
    sum      = (state == MUL) ? acc_r + prod : acc_r;
    shifted  = sgn_r ? (sum >>> P) : (sum >> P);
  end

  // FSM next state and handshake outputs.
  always_comb begin
    state_nxt       = state;
    bus.in_ready_o  = (state == IDLE);
    bus.out_valid_o = (state != IDLE);
    bus.out_last_o  = (state == DRAIN) && last_out;
    bus.out_digit_o = (state == IDLE) ? '0 : sum[P-1:0];
    hs_in           = bus.in_valid_i && (state == IDLE);
    hs_out          = bus.out_ready_i && (state != IDLE);
    case (state)
      IDLE:    if (bus.in_valid_i)      state_nxt = MUL;
      MUL:     if (hs_out && last_mul)  state_nxt = DRAIN;
      DRAIN:   if (hs_out && last_out)  state_nxt = IDLE;
      default:                          state_nxt = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Operand capture on accept; accumulator and digit advance on each output handshake.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      a_r   <= '0;
      b_r   <= '0;
      sgn_r <= 1'b0;
      n_r   <= '0;
      cnt_r <= '0;
      acc_r <= '0;
    end else if (hs_in) begin
      a_r   <= a_ext;
      b_r   <= bus.b_i;
      sgn_r <= bus.signed_i;
      n_r   <= n_clamp;
      cnt_r <= '0;
      acc_r <= {{P{c_ext[MAX_WIDTH]}}, c_ext};
    end else if (hs_out) begin
      acc_r <= shifted;
      cnt_r <= cnt_r + 1'b1;
      if (state == MUL) b_r <= b_r >> P;
    end
  end
endmodule
